// File: rtl/snooper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snooper_pkg
// Brief    : Shared FSM encoding and sizing helper for the snooper tap.
// Revision : 1.0  initial release
// ============================================================================
`ifndef CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package snooper_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARMED = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_DROP  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/snooper_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : snooper_fsm_if
// Brief    : Observed AXI-Stream, packet-memory write bus and core handshakes.
// Revision : 1.0  initial release
// ============================================================================
interface snooper_fsm_if #(
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 8,
    parameter int INC_WIDTH         = `CLOG2(SN_FWD_DATA_WIDTH / 8) + 1,
    parameter int DROP_CNT_WIDTH    = 16
);

    logic [SN_FWD_DATA_WIDTH-1:0]   snoop_TDATA;
    logic [SN_FWD_DATA_WIDTH/8-1:0] snoop_TKEEP;
    logic                           snoop_TVALID;
    logic                           snoop_TREADY;
    logic                           snoop_TLAST;

    logic [SN_FWD_ADDR_WIDTH-1:0]   sn_addr;
    logic [SN_FWD_DATA_WIDTH-1:0]   sn_wr_data;
    logic                           sn_wr_en;
    logic [INC_WIDTH-1:0]           sn_byte_inc;
    logic                           sn_done;
    logic                           sn_done_ack;
    logic                           rdy_for_sn;
    logic                           rdy_for_sn_ack;
    logic [DROP_CNT_WIDTH-1:0]      drop_cnt;

    // Snooper side: observes the stream, drives the memory write bus.
    modport master (
        input  snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST,
        input  sn_done_ack, rdy_for_sn,
        output sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done,
        output rdy_for_sn_ack, drop_cnt
    );

    modport slave (
        output snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST,
        output sn_done_ack, rdy_for_sn,
        input  sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done,
        input  rdy_for_sn_ack, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/snooper_fsm_keep_popcount.sv
`default_nettype none
// ============================================================================
// Module   : keep_popcount
// Brief    : Combinational count of set TKEEP bits (valid bytes per beat).
// Revision : 1.0  initial release
// ============================================================================
module keep_popcount #(
    parameter int KEEP_WIDTH = 8,
    parameter int INC_WIDTH  = 4
) (
    input  logic [KEEP_WIDTH-1:0] i_keep,
    output logic [INC_WIDTH-1:0]  o_count
);

    logic [INC_WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_sum = w_sum + INC_WIDTH'(i_keep[i]);
        end
    end

    assign o_count = w_sum;

endmodule

`default_nettype wire

// File: rtl/snooper_fsm.sv
`default_nettype none
// ============================================================================
// Module   : snooper_fsm
// Brief    : Passive stream tap writing whole packets into a claimed buffer.
// Revision : 1.0  initial release
// ============================================================================
module snooper_fsm
    import snooper_pkg::*;
#(
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 8,
    parameter int INC_WIDTH         = `CLOG2(SN_FWD_DATA_WIDTH / 8) + 1,
    parameter int DROP_CNT_WIDTH    = 16
) (
    input  logic           clk,
    input  logic           rst,
    snooper_fsm_if.master  bus
);

    localparam int c_KEEP_W = SN_FWD_DATA_WIDTH / 8;
    localparam logic [SN_FWD_ADDR_WIDTH:0] c_WCNT_ONE = {{SN_FWD_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DROP_CNT_WIDTH-1:0]  c_DROP_ONE = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0]         r_state;
    logic [c_STATE_W-1:0]         w_next_state;
    logic                         r_sop;
    logic [SN_FWD_ADDR_WIDTH:0]   r_wcnt;
    logic [SN_FWD_ADDR_WIDTH-1:0] r_addr;
    logic [SN_FWD_DATA_WIDTH-1:0] r_wr_data;
    logic                         r_wr_en;
    logic [INC_WIDTH-1:0]         r_byte_inc;
    logic                         r_done;
    logic                         r_claim_ack;
    logic [DROP_CNT_WIDTH-1:0]    r_drop_cnt;

    logic                         w_beat;
    logic                         w_sop_beat;
    logic                         w_write;
    logic [SN_FWD_ADDR_WIDTH-1:0] w_write_addr;
    logic                         w_drop;
    logic                         w_claim;
    logic [INC_WIDTH-1:0]         w_keep_cnt;

    assign w_beat     = bus.snoop_TVALID & bus.snoop_TREADY;
    assign w_sop_beat = w_beat & r_sop;

    keep_popcount #(
        .KEEP_WIDTH (c_KEEP_W),
        .INC_WIDTH  (INC_WIDTH)
    ) u_keep_popcount (
        .i_keep  (bus.snoop_TKEEP),
        .o_count (w_keep_cnt)
    );

    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_write_addr = '0;
        w_drop       = 1'b0;
        w_claim      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // A claim in the same cycle as a packet start still drops that packet.
                if (bus.rdy_for_sn) begin
                    w_claim      = 1'b1;
                    w_next_state = c_ST_ARMED;
                end
                if (w_sop_beat) begin
                    w_drop = 1'b1;
                    if (!bus.rdy_for_sn && !bus.snoop_TLAST) begin
                        w_next_state = c_ST_DROP;
                    end
                end
            end
            c_ST_ARMED: begin
                if (w_sop_beat) begin
                    w_write      = 1'b1;
                    w_next_state = bus.snoop_TLAST ? c_ST_DONE : c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                if (w_beat) begin
                    // Top counter bit set means the buffer is full: truncate.
                    w_write      = ~r_wcnt[SN_FWD_ADDR_WIDTH];
                    w_write_addr = r_wcnt[SN_FWD_ADDR_WIDTH-1:0];
                    if (bus.snoop_TLAST) begin
                        w_next_state = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                if (w_sop_beat) begin
                    w_drop = 1'b1;
                end
                if (r_done && bus.sn_done_ack) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_DROP: begin
                if (w_beat && bus.snoop_TLAST) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sop       <= 1'b1;
            r_wcnt      <= '0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_byte_inc  <= '0;
            r_done      <= 1'b0;
            r_claim_ack <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_claim_ack <= w_claim;
            r_done      <= (r_state == c_ST_DONE) && !(r_done && bus.sn_done_ack);
            r_wr_en     <= w_write;
            r_byte_inc  <= w_write ? w_keep_cnt : '0;
            if (w_beat) begin
                r_sop <= bus.snoop_TLAST;
            end
            if (w_write) begin
                r_addr    <= w_write_addr;
                r_wr_data <= bus.snoop_TDATA;
            end
            if (r_state == c_ST_ARMED && w_sop_beat) begin
                r_wcnt <= c_WCNT_ONE;
            end else if (w_write) begin
                r_wcnt <= r_wcnt + c_WCNT_ONE;
            end
            if (w_drop && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
        end
    end

    assign bus.sn_addr        = r_addr;
    assign bus.sn_wr_data     = r_wr_data;
    assign bus.sn_wr_en       = r_wr_en;
    assign bus.sn_byte_inc    = r_byte_inc;
    assign bus.sn_done        = r_done;
    assign bus.rdy_for_sn_ack = r_claim_ack;
    assign bus.drop_cnt       = r_drop_cnt;

endmodule

`default_nettype wire
